scan_mux_reg: RTL and testbench
===============================

// Module: scan_mux_reg
// PURPOSE
//   Registered N-channel, W-bit selector. Generalises the 3-input/2-bit-select
//   registered mux: parametrised channel count and width, plus a hardware
//   auto-scan mode that steps through channels with a programmable dwell.
//   Sits between lab input banks (switches/sensors) and display/LED drivers.
// PARAMETERS
//   N_CH   4   number of input channels (2..16)
//   W      1   data width per channel (1..32)
//   DWELL  8   clock cycles spent on each channel in scan mode (1..2^16)
//   SELW   $clog2(N_CH) (derived localparam, not overridable)
// PORTS
//   clk        in   1         rising-edge clock, the only clock
//   reset_n    in   1         asynchronous, active-low reset
//   din        in   N_CH*W    packed channels; ch k = din[k*W +: W]
//   sel        in   SELW      manual channel select
//   mode       in   1         0 = MANUAL, 1 = SCAN
//   en         in   1         1 = update; 0 = freeze all state
//   dout       out  W         registered selected data
//   cur_ch     out  SELW      registered index of channel driving dout
//   scan_wrap  out  1         1-cycle pulse when scan wraps N_CH-1 -> 0
// BEHAVIOUR
//   - Reset (reset_n=0, async assert, sync-released): dout=0, cur_ch=0,
//     scan_wrap=0, dwell count=0. Reset mid-scan aborts the scan immediately.
//   - Latency: dout/cur_ch reflect inputs sampled at the prior clk edge (1 cycle).
//   - en=0: dout, cur_ch, dwell count hold; scan_wrap forced 0. Priority:
//     reset > en > mode.
//   - MANUAL: each enabled edge cur_ch<=sel, dout<=ch[sel]. sel>=N_CH
//     (non-power-of-2 N_CH) -> dout<=0, cur_ch<=N_CH-1 is NOT used; cur_ch<=sel.
//     Dwell count held at 0.
//   - SCAN: dout<=ch[cur_ch] every enabled edge (live data, not snapshot).
//     Dwell count 0..DWELL-1; at DWELL-1 count<=0 and cur_ch advances.
//     cur_ch=N_CH-1 advance -> cur_ch<=0 and scan_wrap=1 for that cycle.
//     DWELL=1: channel advances every enabled cycle.
//   - MANUAL->SCAN: scan starts from current cur_ch (clamped to N_CH-1 if
//     out of range), dwell count restarts at 0. SCAN->MANUAL: next edge
//     follows sel; dwell count cleared.
//   - States: MANUAL, SCAN (selected directly by mode; no hidden states).
//   - Widths: dwell counter $clog2(DWELL+1) bits, no overflow possible.
// CONFIGURATION
//   SCAN_MUX_PARITY_EN defined: extra output dout_par (1 bit) = even parity
//     (^dout) registered alongside dout, same latency/reset (0)/freeze rules.
//   Undefined: port dout_par absent; no parity logic.
// STRUCTURE
//   scan_mux_defs.vh: MODE_MANUAL/MODE_SCAN encodings, SELW derivation macro.
//   Sub-module dwell_counter (params MAX; ports clk, reset_n, en, clr,
//   tick) produces the advance strobe; the top holds channel reg and mux.
// TESTING
//   1. reset_n=0 while din toggling -> dout=0, cur_ch=0, scan_wrap=0 at once.
//   2. MANUAL, N_CH=4,W=4, din=16'hDCBA, sel=2 -> dout=4'hC one edge later.
//   3. SCAN, DWELL=3 -> cur_ch 0,0,0,1,1,1,2,2,2,3,3,3,0; scan_wrap=1 only
//      on the 3->0 cycle.
//   4. en=0 for 5 cycles mid-scan -> dout/cur_ch hold; resumes same dwell
//      position; no spurious scan_wrap.
//   5. N_CH=3, MANUAL sel=3 -> dout=0; switch to SCAN -> cur_ch starts at 2.
//   6. SCAN_MUX_PARITY_EN, W=4, selected ch=4'b1011 -> dout_par=1 with dout.

Source files
------------

// File: rtl/scan_mux_reg_pkg.sv
// Shared types and helpers for the scan_mux_reg selector (mode encodings, parity).
package scan_mux_reg_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic logic even_par32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/scan_mux_reg_dwell_counter.sv
// Dwell counter for scan mode: counts 0..MAX-1 and strobes tick on the last count.
module dwell_counter
    import scan_mux_reg_pkg::*;
#(
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW   = $clog2(MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // tick is combinational so the channel register can advance on the same edge
    assign tick = en & ~clr & (cnt_q == LAST);

    // next count: hold when disabled, clear in manual, wrap at the last dwell cycle
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = cnt_q;
        end else if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N_CH x W selector with manual select and auto-scan mode.
// Define SCAN_MUX_PARITY_EN to add the registered even-parity output dout_par.
module scan_mux_reg
    import scan_mux_reg_pkg::*;
#(
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned W     = 1,
    parameter  int unsigned DWELL = 8,
    localparam int unsigned SELW  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH*W-1:0] din,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   cur_ch,
    output logic              scan_wrap
`ifdef SCAN_MUX_PARITY_EN
    ,
    output logic              dout_par
`endif
);

    localparam int unsigned   NSLOT   = 1 << SELW;
    localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

    mode_e             mode_s;
    logic              tick_s;
    logic [W-1:0]      ch_s [NSLOT];
    logic [SELW-1:0]   start_s;
    logic [SELW-1:0]   next_ch_s;
    logic [SELW-1:0]   cur_ch_q, cur_ch_d;
    logic [W-1:0]      dout_q, dout_d;
    logic              wrap_q, wrap_d;

    assign mode_s = mode_e'(mode);

    // Unused select codes (non-power-of-2 N_CH) read as zero
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < N_CH) begin : g_real
            assign ch_s[k] = din[k*W +: W];
        end else begin : g_pad
            assign ch_s[k] = '0;
        end
    end

    dwell_counter #(
        .MAX     (DWELL)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (mode_s == MODE_MANUAL),
        .tick    (tick_s)
    );

    // Channel choice and next-state for the output registers
    always_comb begin
        start_s   = (cur_ch_q > LAST_CH) ? LAST_CH : cur_ch_q;
        next_ch_s = cur_ch_q;
        cur_ch_d  = cur_ch_q;
        dout_d    = dout_q;
        wrap_d    = 1'b0;
        if (!en) begin
            cur_ch_d = cur_ch_q;
            dout_d   = dout_q;
            wrap_d   = 1'b0;
        end else begin
            case (mode_s)
                MODE_MANUAL: begin
                    next_ch_s = sel;
                    wrap_d    = 1'b0;
                end
                MODE_SCAN: begin
                    if (tick_s) begin
                        next_ch_s = (start_s == LAST_CH) ? '0 : start_s + SELW'(1);
                    end else begin
                        next_ch_s = start_s;
                    end
                    wrap_d = tick_s & (start_s == LAST_CH);
                end
                default: begin
                    next_ch_s = cur_ch_q;
                    wrap_d    = 1'b0;
                end
            endcase
            cur_ch_d = next_ch_s;
            dout_d   = ch_s[next_ch_s];
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_ch_q <= '0;
            dout_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            cur_ch_q <= cur_ch_d;
            dout_q   <= dout_d;
            wrap_q   <= wrap_d;
        end
    end

    assign dout      = dout_q;
    assign cur_ch    = cur_ch_q;
    assign scan_wrap = wrap_q;

`ifdef SCAN_MUX_PARITY_EN
    logic par_q;
    logic par_d;

    assign par_d = en ? even_par32(32'(dout_d)) : par_q;

    // Parity register, follows dout's reset and freeze behaviour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign dout_par = par_q;
`endif

endmodule

// File: tb/tb_scan_mux_reg.sv
// Self-checking bench for scan_mux_reg: two instances (N_CH=4/DWELL=3, N_CH=3/DWELL=2), directed + random.
module tb_scan_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, mode, en;
    logic [15:0] din4;
    logic [11:0] din3;
    logic [1:0]  sel4, sel3;
    logic [3:0]  dout4, dout3;
    logic [1:0]  cur4, cur3;
    logic        wrap4, wrap3;
`ifdef SCAN_MUX_PARITY_EN
    logic        par4, par3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference state: channel, dwell position, expected dout and wrap per instance
    int m_ch [2];
    int m_cnt[2];
    int m_dout[2];
    int m_wrap[2];

    scan_mux_reg #(.N_CH(4), .W(4), .DWELL(3)) dut4 (
        .clk(clk), .reset_n(reset_n), .din(din4), .sel(sel4), .mode(mode), .en(en),
        .dout(dout4), .cur_ch(cur4), .scan_wrap(wrap4)
`ifdef SCAN_MUX_PARITY_EN
        , .dout_par(par4)
`endif
    );

    scan_mux_reg #(.N_CH(3), .W(4), .DWELL(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .din(din3), .sel(sel3), .mode(mode), .en(en),
        .dout(dout3), .cur_ch(cur3), .scan_wrap(wrap3)
`ifdef SCAN_MUX_PARITY_EN
        , .dout_par(par3)
`endif
    );

    function automatic int chan(input logic [15:0] d, input int c, input int n);
        logic [15:0] sh;
        if (c >= n) return 0;
        sh = d >> (4 * c);
        return int'(sh & 16'h000F);
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            m_ch[k] = 0; m_cnt[k] = 0; m_dout[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_one(input int k, input int n, input int dw,
                             input logic [15:0] d, input int s);
        int c;
        if (!en) begin
            m_wrap[k] = 0;
            return;
        end
        if (!mode) begin
            m_ch[k]   = s;
            m_cnt[k]  = 0;
            m_wrap[k] = 0;
        end else begin
            c = (m_ch[k] > n - 1) ? n - 1 : m_ch[k];
            m_cnt[k]  = m_cnt[k] + 1;
            m_wrap[k] = 0;
            if (m_cnt[k] == dw) begin
                m_cnt[k]  = 0;
                c         = (c + 1) % n;
                m_wrap[k] = (c == 0) ? 1 : 0;
            end
            m_ch[k] = c;
        end
        m_dout[k] = chan(d, m_ch[k], n);
    endtask

    task automatic model_all();
        if (!reset_n) begin
            model_zero();
        end else begin
            model_one(0, 4, 3, din4, int'(sel4));
            model_one(1, 3, 2, {4'b0000, din3}, int'(sel3));
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic par_of(input int v);
        logic [3:0] b;
        b = v[3:0];
        return ^b;
    endfunction

    task automatic check_all();
        chk("dout4",  dout4, m_dout[0]);
        chk("cur4",   cur4,  m_ch[0]);
        chk("wrap4",  wrap4, m_wrap[0]);
        chk("dout3",  dout3, m_dout[1]);
        chk("cur3",   cur3,  m_ch[1]);
        chk("wrap3",  wrap3, m_wrap[1]);
`ifdef SCAN_MUX_PARITY_EN
        chk("par4", par4, par_of(m_dout[0]));
        chk("par3", par3, par_of(m_dout[1]));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_all();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_din();
        din4 = 16'($urandom);
        din3 = 12'($urandom);
    endtask

    // called just after a negedge: reset must clear the outputs without a clock edge
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        model_zero();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int exp_seq[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    initial begin
        reset_n = 1'b0; mode = 1'b0; en = 1'b1;
        sel4 = 2'd0; sel3 = 2'd0;
        rand_din();
        model_zero();
        #1;
        check_all();
        repeat (3) begin
            rand_din();
            step();
        end
        reset_n = 1'b1;

        // manual select of channel 2
        din4 = 16'hDCBA; sel4 = 2'd2; mode = 1'b0;
        step();
        chk("manual_sel2", dout4, 32'h0000000C);

        // scan from channel 0, DWELL=3
        sel4 = 2'd0; sel3 = 2'd0;
        step();
        mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_din();
            step();
            chk("scan_seq", cur4, exp_seq[i]);
            chk("scan_wrap_only_3to0", wrap4, (i == 11) ? 1 : 0);
        end

        // freeze mid-dwell, then resume
        repeat (2) begin rand_din(); step(); end
        en = 1'b0;
        repeat (5) begin rand_din(); step(); end
        en = 1'b1;
        repeat (8) begin rand_din(); step(); end

        // reset in the middle of a scan
        async_reset();
        repeat (4) begin rand_din(); step(); end

        // N_CH=3 out-of-range manual select, then scan starts clamped
        mode = 1'b0; sel3 = 2'd3;
        step();
        chk("n3_oob_dout", dout3, 32'h0);
        chk("n3_oob_cur", cur3, 32'h3);
        mode = 1'b1;
        step();
        chk("n3_clamp", cur3, 32'h2);

        // channel value 4'b1011 (odd weight) selected
        mode = 1'b0; sel4 = 2'd1; din4 = 16'h00B0;
        step();
        chk("sel_1011", dout4, 32'hB);
`ifdef SCAN_MUX_PARITY_EN
        chk("par_1011", par4, 32'h1);
`endif

        // random mix of modes, freezes, selects and resets
        repeat (300) begin
            rand_din();
            sel4 = 2'($urandom);
            sel3 = 2'($urandom);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 49) == 0) async_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
